// File: rtl/turtle_pkg.sv
// Shared types for the fetch slice: FSM state encoding, fault cause codes
// and the NOP instruction. No ports; imported with import turtle_pkg::*.
package turtle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT,
        S_DRAIN
    } fetch_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_BUS      = 2'd1,
        CAUSE_TIMEOUT  = 2'd2,
        CAUSE_MISALIGN = 2'd3
    } fault_cause_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
// Signals: mem_req/mem_addr (request), mem_gnt, mem_rvalid/mem_rdata/mem_err.
interface inst_fetch_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        output mem_err
    );

endinterface

// File: rtl/inst_fetch_imm_decode.sv
// Combinational J/B immediate decoder, shared with the decode stage.
// Ports: inst (in 32), imm_j (out 32), imm_b (out 32), both sign-extended.
module imm_decode (
    input  logic [31:0] inst,
    output logic [31:0] imm_j,
    output logic [31:0] imm_b
);

    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20],
                    inst[30:21], 1'b0};

    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25],
                    inst[11:8], 1'b0};

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one word read per fetch_start, holds the result,
// handles flush, bus error and timeout. Optional macro
// FETCH_MISALIGN_CHECK_EN faults misaligned PCs (cause 3) instead of masking.
// Ports: clk, reset (sync, active-high), pc_in, fetch_start, fetch_flush,
//  mem (inst_fetch_if.master), inst_valid, inst_out, inst_imm_j, inst_imm_b,
//  fetch_busy, fetch_fault, fault_cause.
module inst_fetch
    import turtle_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_in,
    input  logic                fetch_start,
    input  logic                fetch_flush,
    inst_fetch_if.master        mem,
    output logic                inst_valid,
    output logic [31:0]         inst_out,
    output logic [31:0]         inst_imm_j,
    output logic [31:0]         inst_imm_b,
    output logic                fetch_busy,
    output logic                fetch_fault,
    output logic [1:0]          fault_cause
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    fetch_state_e  state_q, state_d;
    fault_cause_e  cause_q, cause_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   inst_q, inst_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (fetch_flush) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    cause_d = CAUSE_NONE;
                end else if (fetch_start) begin
                    valid_d = 1'b0;
                    cause_d = CAUSE_NONE;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        addr_d  = pc_in;
                        state_d = S_REQ;
                    end
`else
                    addr_d  = pc_in & ~32'h3;
                    state_d = S_REQ;
`endif
                end
            end

            S_REQ: begin
                if (fetch_flush) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                end else if (mem.mem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_WAIT: begin
                if (fetch_flush) begin
                    // A response arriving with the flush settles the debt.
                    state_d = mem.mem_rvalid ? S_IDLE : S_DRAIN;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    cnt_d   = '0;
                end else if (mem.mem_rvalid) begin
                    if (mem.mem_err) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_BUS;
                    end else begin
                        state_d = S_DONE;
                        inst_d  = mem.mem_rdata;
                        valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DRAIN: begin
                if (mem.mem_rvalid || cnt_q == CNT_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_d   = (state_d == S_REQ);
        busy_d  = (state_d == S_REQ) || (state_d == S_WAIT) ||
                  (state_d == S_DRAIN);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign inst_valid   = valid_q;
    assign inst_out     = inst_q;
    assign fetch_busy   = busy_q;
    assign fetch_fault  = fault_q;
    assign fault_cause  = cause_q;

    imm_decode u_imm (
        .inst  (inst_q),
        .imm_j (inst_imm_j),
        .imm_b (inst_imm_b)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed corner cases plus randomized
// fetches against a reference model of expected instruction/fault results.
module tb_inst_fetch;

    localparam int TO = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          gd;
        int          rd;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        fetch_start = 1'b0;
    logic        fetch_flush = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_imm_j;
    logic [31:0] inst_imm_b;
    logic        fetch_busy;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    logic        a_gnt = 0, a_rv = 0, a_err = 0;
    logic [31:0] a_data = '0;
    logic        m_gnt = 0, m_rv = 0, m_err = 0;
    logic [31:0] m_data = '0;
    logic        auto_mem = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [31:0] model_inst = NOP;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    inst_fetch_if mif();

    assign mif.mem_gnt    = a_gnt | m_gnt;
    assign mif.mem_rvalid = a_rv | m_rv;
    assign mif.mem_rdata  = a_rv ? a_data : m_data;
    assign mif.mem_err    = a_rv ? a_err : m_err;

    inst_fetch #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .fetch_start (fetch_start),
        .fetch_flush (fetch_flush),
        .mem         (mif.master),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_imm_j  (inst_imm_j),
        .inst_imm_b  (inst_imm_b),
        .fetch_busy  (fetch_busy),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Immediates rebuilt as plain signed offsets from the field weights.
    function automatic logic [31:0] ref_imm_j(input logic [31:0] i);
        int v;
        v = (int'(i[30:21]) * 2) + (int'(i[20]) * 2048) +
            (int'(i[19:12]) * 4096) - (int'(i[31]) * 1048576);
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_imm_b(input logic [31:0] i);
        int v;
        v = (int'(i[11:8]) * 2) + (int'(i[30:25]) * 32) +
            (int'(i[7]) * 2048) - (int'(i[31]) * 4096);
        return 32'(v);
    endfunction

    // Monitor: every new inst_valid or fetch_fault is one completed fetch.
    initial begin
        logic pv, pf;
        exp_t e;
        pv = 0;
        pf = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && ((inst_valid && !pv) || (fetch_fault && !pf))) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_out", inst_out, e.inst);
                    chk("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
                    chk("inst_valid", {31'd0, inst_valid},
                        {31'd0, (e.cause == 2'd0)});
                    chk("fetch_fault", {31'd0, fetch_fault},
                        {31'd0, (e.cause != 2'd0)});
                    chk("imm_j", inst_imm_j, ref_imm_j(e.inst));
                    chk("imm_b", inst_imm_b, ref_imm_b(e.inst));
                end
                done_cnt++;
            end
            pv = inst_valid;
            pf = fetch_fault;
        end
    end

    // Memory responder driven from the response queue.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (auto_mem && mif.mem_req) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_queue_empty", 32'd1, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    for (int k = 0; k < r.gd; k++) begin
                        chk("addr_hold", mif.mem_addr, r.addr);
                        chk("req_hold", {31'd0, mif.mem_req}, 32'd1);
                        @(negedge clk);
                    end
                    chk("mem_addr", mif.mem_addr, r.addr);
                    a_gnt = 1;
                    @(negedge clk);
                    a_gnt = 0;
                    for (int k = 1; k < r.rd; k++) @(negedge clk);
                    a_rv = 1;
                    a_data = r.data;
                    a_err = r.err;
                    @(negedge clk);
                    a_rv = 0;
                    a_err = 0;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input int gd, input int rd,
                         input logic [31:0] data, input logic err);
        rsp_t r;
        exp_t e;
        int d0;
        r.addr = pc & ~32'h3;
        r.gd = gd;
        r.rd = rd;
        r.data = data;
        r.err = err;
        rsp_q.push_back(r);
        e.cause = err ? 2'd1 : 2'd0;
        e.inst = err ? model_inst : data;
        if (!err) model_inst = data;
        exp_q.push_back(e);
        d0 = done_cnt;
        @(negedge clk);
        pc_in = pc;
        fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
        chk("req_latency", {31'd0, mif.mem_req}, 32'd1);
        for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) chk("fetch_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_pulse(input logic [31:0] pc);
        @(negedge clk);
        pc_in = pc;
        fetch_start = 1;
        @(negedge clk);
        fetch_start = 0;
    endtask

    initial begin
        exp_t e;
        int w;
        logic [31:0] pc;

        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, mif.mem_req}, 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst_out, NOP);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        reset = 0;

        // Reset while a request is pending.
        start_pulse(32'h40);
        chk("midreset_req_pre", {31'd0, mif.mem_req}, 32'd1);
        reset = 1;
        @(negedge clk);
        chk("midreset_req", {31'd0, mif.mem_req}, 32'd0);
        chk("midreset_busy", {31'd0, fetch_busy}, 32'd0);
        reset = 0;

        auto_mem = 1;
        fetch(32'h100, 0, 1, 32'h0080006F, 0);
        chk("jal_imm_j", inst_imm_j, 32'h8);
        fetch(32'h100, 3, 2, 32'hFE000EE3, 0);
        fetch(32'h200, 1, 2, 32'h12345678, 1);
`ifndef FETCH_MISALIGN_CHECK_EN
        fetch(32'h102, 0, 1, 32'h00A00513, 0);
`endif

        // Flush from DONE invalidates the held word.
        @(negedge clk);
        fetch_flush = 1;
        @(negedge clk);
        fetch_flush = 0;
        model_inst = NOP;
        chk("done_flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("done_flush_inst", inst_out, NOP);

        auto_mem = 0;
        // Timeout after grant, then a stray response.
        e.cause = 2'd2;
        e.inst = model_inst;
        exp_q.push_back(e);
        start_pulse(32'h300);
        m_gnt = 1;
        @(negedge clk);
        m_gnt = 0;
        w = 1;
        @(negedge clk);
        while (!fetch_fault && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("timeout_window", {31'd0, (w == TO || w == TO + 1)}, 32'd1);
        m_rv = 1;
        m_data = 32'hCAFEF00D;
        @(negedge clk);
        m_rv = 0;
        @(negedge clk);
        chk("stray_fault", {31'd0, fetch_fault}, 32'd1);
        chk("stray_cause", {30'd0, fault_cause}, 32'd2);
        chk("stray_inst", inst_out, model_inst);

        // Flush in WAIT, response two cycles later is discarded.
        start_pulse(32'h400);
        m_gnt = 1;
        @(negedge clk);
        m_gnt = 0;
        fetch_flush = 1;
        @(negedge clk);
        fetch_flush = 0;
        model_inst = NOP;
        chk("drain_busy", {31'd0, fetch_busy}, 32'd1);
        @(negedge clk);
        m_rv = 1;
        m_data = 32'hDEADBEEF;
        @(negedge clk);
        m_rv = 0;
        chk("drain_idle", {31'd0, fetch_busy}, 32'd0);
        chk("drain_inst", inst_out, NOP);
        chk("drain_valid", {31'd0, inst_valid}, 32'd0);

        // Flush together with the response: straight to idle.
        start_pulse(32'h500);
        m_gnt = 1;
        @(negedge clk);
        m_gnt = 0;
        fetch_flush = 1;
        m_rv = 1;
        m_data = 32'h11111111;
        @(negedge clk);
        fetch_flush = 0;
        m_rv = 0;
        chk("flush_rv_idle", {31'd0, fetch_busy}, 32'd0);
        chk("flush_rv_inst", inst_out, NOP);

        // Start and flush together: flush wins.
        @(negedge clk);
        pc_in = 32'h600;
        fetch_start = 1;
        fetch_flush = 1;
        @(negedge clk);
        fetch_start = 0;
        fetch_flush = 0;
        chk("startflush_req", {31'd0, mif.mem_req}, 32'd0);

        // Flush in REQ drops the request.
        start_pulse(32'h700);
        fetch_flush = 1;
        @(negedge clk);
        fetch_flush = 0;
        chk("reqflush_req", {31'd0, mif.mem_req}, 32'd0);
        chk("reqflush_busy", {31'd0, fetch_busy}, 32'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
        e.cause = 2'd3;
        e.inst = model_inst;
        exp_q.push_back(e);
        start_pulse(32'h102);
        chk("misalign_req", {31'd0, mif.mem_req}, 32'd0);
        @(negedge clk);
        chk("misalign_req2", {31'd0, mif.mem_req}, 32'd0);
`endif

        auto_mem = 1;
        for (int n = 0; n < 40; n++) begin
            pc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            pc[1:0] = 2'b00;
`endif
            fetch(pc, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                  $urandom, ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
